mixer_tune_ctrl: RTL and testbench
==================================

Name: mixer_tune_ctrl

Overview:
- Retune sequencer for the 1-bit AM receiver's quadrature mixer.
- Owns the NCO phase accumulator and emits the LUT phase index that drives the sin/cos ROM feeding the mixer.
- On a tuning request it mutes the mixer, swaps the phase increment, pulses a flush to the downstream decimation filters, waits a settle period, then reports tuned.
- Sits between the control/UART register block and the NCO ROM + mixer + CIC chain.

Parameters:
- PHASE_BITS, 32, phase accumulator and tuning word width.
- LUT_BITS, 10, phase index width to sin/cos ROM (top bits of accumulator).
- MUTE_CYCLES, 16, cycles mix_en held low before increment swap (>=1).
- SETTLE_CYCLES, 1024, cycles after flush before tuned asserts (>=1).
- CNT_BITS, 16, width of internal cycle counter (must hold max(MUTE_CYCLES, SETTLE_CYCLES)).

Ports:
- CLK  in  1  system clock.
- RSTb  in  1  asynchronous active-low reset.
- req_valid  in  1  tuning request valid.
- req_freq  in  PHASE_BITS  requested phase increment (unsigned).
- req_phase_clr  in  1  sampled with req_freq; 1 = zero accumulator at swap.
- req_ready  out  1  controller can accept a request.
- phase_idx  out  LUT_BITS  registered accumulator[PHASE_BITS-1 -: LUT_BITS].
- mix_en  out  1  mixer/ROM output gate; 0 = downstream treats I/Q as zero.
- flush  out  1  one-cycle pulse clearing CIC/decimator state.
- tuned  out  1  level, 1 = stable at current frequency.
- cur_freq  out  PHASE_BITS  increment currently in use.

Behaviour:
- Reset (RSTb=0, async): state=IDLE; acc=0; inc=0; cur_freq=0; phase_idx=0; mix_en=0; flush=0; tuned=0; req_ready=0 for that cycle; counter=0.
- Accumulator: acc <= acc + inc every cycle in every state, with modulo 2^PHASE_BITS wrap and no saturation. phase_idx <= acc top bits (1-cycle registered latency after acc).
- Handshake:
  - req_ready=1 only in IDLE and RUN.
  - Transfer occurs when req_valid & req_ready on a rising edge; freq and phase_clr are captured into holding regs.
  - req_valid while busy is ignored (no queue); the requester holds valid until ready.
- States:
  - IDLE: mix_en=0, tuned=0. On transfer -> MUTE, counter=0.
  - MUTE: mix_en=0, tuned=0. counter increments; when counter==MUTE_CYCLES-1 -> SWAP.
  - SWAP (1 cycle): inc <= held freq; cur_freq <= held freq; if phase_clr then acc <= 0 (overrides the add that cycle). flush=1 this cycle. -> SETTLE, counter=0.
  - SETTLE: mix_en=1, tuned=0. counter increments; when counter==SETTLE_CYCLES-1 -> RUN.
  - RUN: mix_en=1, tuned=1. On transfer -> MUTE with tuned=0 and mix_en=0 from the next cycle.
- Timing from transfer edge T:
  - MUTE occupies T+1..T+MUTE_CYCLES.
  - SWAP at T+MUTE_CYCLES+1 (flush high).
  - tuned rises at T+MUTE_CYCLES+SETTLE_CYCLES+2.
- Boundary conditions:
  - req_freq=0 is legal: NCO frozen, sequence runs normally.
  - Same freq as cur_freq still runs the full sequence.
  - flush is exactly one cycle per accepted request, never otherwise.
  - RSTb asserted mid-sequence aborts immediately to reset values. The held request is lost, and flush never glitches high.
  - req_valid sampled in the same cycle as reset release is ignored (req_ready=0 during reset).
- All outputs registered; no combinational path from req_* to outputs except req_ready, which is decoded from state only.

Test Plan:
- Reset then idle, MUTE_CYCLES=4, SETTLE_CYCLES=8: all outputs 0; req_ready=1 one cycle after RSTb rises; acc static at 0.
- Request 0x0100_0000 with phase_clr=1 at edge T:
  - mix_en stays 0 through T+5.
  - flush=1 only at T+5.
  - cur_freq=0x0100_0000 after T+5.
  - tuned=1 at T+14.
  - phase_idx advances 4 per cycle (LUT_BITS=10) starting from 0.
- Accumulator wrap: inc=0xFFFF_FFFF, run 3 cycles from 0 -> acc=0xFFFF_FFFF, 0xFFFF_FFFE, 0xFFFF_FFFD; phase_idx=0x3FF.
- Retune from RUN to 0x0200_0000, phase_clr=0: tuned falls next cycle; accumulator is not cleared (continuous); new increment takes effect after flush cycle.
- Busy rejection: hold req_valid during MUTE/SETTLE -> req_ready=0, no extra flush; the request is accepted the first RUN cycle, exactly one further flush.
- Reset mid-SETTLE: assert RSTb=0 asynchronously -> mix_en, tuned, flush, cur_freq, phase_idx all 0 before next clock edge; state IDLE after release.

Source files
------------

// File: rtl/mixer_tune_ctrl_if.sv
// Request/status bundle between the control register block and the NCO retune
// sequencer. The control side is the master: it drives the tuning request and
// observes the NCO/mixer status.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. req_freq and req_phase_clr must be stable while
// req_valid is high. The master keeps req_valid high until it sees
// req_ready=1; the slave never queues and never drops a request that has
// transferred.
interface mixer_tune_ctrl_if #(
   parameter int PHASE_BITS = 32,
   parameter int LUT_BITS   = 10
);
   logic                  req_valid;
   logic [PHASE_BITS-1:0] req_freq;
   logic                  req_phase_clr;
   logic                  req_ready;
   logic [LUT_BITS-1:0]   phase_idx;
   logic                  mix_en;
   logic                  flush;
   logic                  tuned;
   logic [PHASE_BITS-1:0] cur_freq;

   modport master (
      output req_valid, req_freq, req_phase_clr,
      input  req_ready, phase_idx, mix_en, flush, tuned, cur_freq
   );

   modport slave (
      input  req_valid, req_freq, req_phase_clr,
      output req_ready, phase_idx, mix_en, flush, tuned, cur_freq
   );
endinterface

// File: rtl/mixer_tune_ctrl.sv
// Retune sequencer for the quadrature mixer NCO. Owns the phase accumulator
// and drives the sin/cos ROM index. A tuning request mutes the mixer, swaps
// the phase increment, pulses flush to the CIC/decimator chain, waits for the
// filters to settle, then raises tuned.
module mixer_tune_ctrl #(
   parameter int PHASE_BITS    = 32,
   parameter int LUT_BITS      = 10,
   parameter int MUTE_CYCLES   = 16,
   parameter int SETTLE_CYCLES = 1024,
   parameter int CNT_BITS      = 16
) (
   input  logic               CLK,
   input  logic               RSTb,
   mixer_tune_ctrl_if.slave   bus,
   output logic [2:0]         o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MUTE   = 3'd1,
      ST_SWAP   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RUN    = 3'd4
   } state_t;

   localparam logic [CNT_BITS-1:0] MUTE_LAST   = CNT_BITS'(MUTE_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(SETTLE_CYCLES - 1);

   state_t                r_state;
   logic [CNT_BITS-1:0]   r_cnt;
   logic [PHASE_BITS-1:0] r_acc;
   logic [PHASE_BITS-1:0] r_inc;
   logic [PHASE_BITS-1:0] r_cur_freq;
   logic [PHASE_BITS-1:0] r_hold_freq;
   logic                  r_hold_clr;
   logic [LUT_BITS-1:0]   r_phase_idx;
   logic                  r_req_ready;
   logic                  r_mix_en;
   logic                  r_flush;
   logic                  r_tuned;
   logic                  w_xfer;

   // req_ready is a register that is only ever 1 while the state is IDLE or
   // RUN, and is held 0 in reset so a request at reset release is ignored.
   assign w_xfer = bus.req_valid & r_req_ready;

   assign bus.req_ready = r_req_ready;
   assign bus.phase_idx = r_phase_idx;
   assign bus.mix_en    = r_mix_en;
   assign bus.flush     = r_flush;
   assign bus.tuned     = r_tuned;
   assign bus.cur_freq  = r_cur_freq;
   assign o_dbg_state   = r_state;

   // NCO: free-running accumulator; the increment is swapped (and the phase
   // optionally zeroed) only in the SWAP cycle. ROM index lags acc by one cycle.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_acc       <= '0;
         r_inc       <= '0;
         r_cur_freq  <= '0;
         r_phase_idx <= '0;
      end else begin
         r_phase_idx <= r_acc[PHASE_BITS-1 -: LUT_BITS];
         if (r_state == ST_SWAP) begin
            r_inc      <= r_hold_freq;
            r_cur_freq <= r_hold_freq;
            r_acc      <= r_hold_clr ? '0 : r_acc + r_inc;
         end else begin
            r_acc <= r_acc + r_inc;
         end
      end
   end

   // Sequencer FSM; every status output is registered alongside the state so
   // it reflects the state being entered.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_hold_freq <= '0;
         r_hold_clr  <= 1'b0;
         r_req_ready <= 1'b0;
         r_mix_en    <= 1'b0;
         r_flush     <= 1'b0;
         r_tuned     <= 1'b0;
      end else begin
         r_flush <= 1'b0;
         case (r_state)
            ST_IDLE, ST_RUN: begin
               if (w_xfer) begin
                  r_state     <= ST_MUTE;
                  r_cnt       <= '0;
                  r_hold_freq <= bus.req_freq;
                  r_hold_clr  <= bus.req_phase_clr;
                  r_req_ready <= 1'b0;
                  r_mix_en    <= 1'b0;
                  r_tuned     <= 1'b0;
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            ST_MUTE: begin
               if (r_cnt == MUTE_LAST) begin
                  r_state <= ST_SWAP;
                  r_cnt   <= '0;
                  r_flush <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_SWAP: begin
               r_state  <= ST_SETTLE;
               r_cnt    <= '0;
               r_mix_en <= 1'b1;
            end
            ST_SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_state     <= ST_RUN;
                  r_cnt       <= '0;
                  r_tuned     <= 1'b1;
                  r_req_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_req_ready <= 1'b0;
               r_mix_en    <= 1'b0;
               r_tuned     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mixer_tune_ctrl.sv
// Bench for mixer_tune_ctrl with short mute/settle windows. A monitor keeps a
// timing-level NCO model and a queue of accepted frequencies; each flush pops
// the queue and the following cycle's cur_freq must match.
module tb_mixer_tune_ctrl;

   localparam int PB = 32;
   localparam int LB = 10;
   localparam int M  = 4;
   localparam int S  = 8;

   logic       clk;
   logic       rst_n;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   mixer_tune_ctrl_if #(.PHASE_BITS(PB), .LUT_BITS(LB)) bus_if ();

   mixer_tune_ctrl #(
      .PHASE_BITS(PB), .LUT_BITS(LB), .MUTE_CYCLES(M),
      .SETTLE_CYCLES(S), .CNT_BITS(16)
   ) dut (
      .CLK(clk),
      .RSTb(rst_n),
      .bus(bus_if),
      .o_dbg_state(dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- monitor: NCO model + flush scoreboard ----------------
   logic [PB-1:0] exp_q[$];
   logic [PB-1:0] m_acc, m_inc, m_cur, m_new, sb_exp;
   logic [LB-1:0] m_pidx;
   logic          m_clr, m_rdy, sb_pending;
   int            m_j;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc = '0; m_inc = '0; m_cur = '0; m_new = '0; m_clr = 1'b0;
         m_pidx = '0; m_rdy = 1'b0; m_j = -1; sb_pending = 1'b0;
         exp_q.delete();
      end else begin
         // state of the world just before this edge
         m_pidx = m_acc[PB-1 -: LB];
         if (m_j == M) begin
            m_acc = m_clr ? '0 : m_acc + m_inc;
            m_inc = m_new;
            m_cur = m_new;
         end else begin
            m_acc = m_acc + m_inc;
         end
         if (m_j >= 0 && m_j < M + S + 1) m_j++;
         if (bus_if.req_valid === 1'b1 && m_rdy) begin
            m_j   = 0;
            m_new = bus_if.req_freq;
            m_clr = bus_if.req_phase_clr;
            exp_q.push_back(bus_if.req_freq);
         end
         m_rdy = (m_j < 0) || (m_j >= M + S + 1);
         #1;
         if (rst_n) begin
            n_checks++;
            if (bus_if.phase_idx !== m_pidx) begin
               n_errors++;
               $display("FAIL mon_phase_idx: got %h expected %h at %0t", bus_if.phase_idx, m_pidx, $time);
            end
            n_checks++;
            if (bus_if.cur_freq !== m_cur) begin
               n_errors++;
               $display("FAIL mon_cur_freq: got %h expected %h at %0t", bus_if.cur_freq, m_cur, $time);
            end
            if (sb_pending) begin
               sb_pending = 1'b0;
               n_checks++;
               if (bus_if.cur_freq !== sb_exp) begin
                  n_errors++;
                  $display("FAIL sb_freq_after_flush: got %h expected %h", bus_if.cur_freq, sb_exp);
               end
            end
            if (bus_if.flush === 1'b1) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL sb_unexpected_flush: flush=1 expected 0 (no pending request) at %0t", $time);
               end else begin
                  sb_exp     = exp_q.pop_front();
                  sb_pending = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_request(input logic [PB-1:0] f, input logic c);
      int t;
      t = 0;
      while (bus_if.req_ready !== 1'b1 && t < 200) begin
         step();
         t++;
      end
      if (bus_if.req_ready !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL req_wait: req_ready=%b expected 1 within 200 cycles", bus_if.req_ready);
      end
      bus_if.req_valid     = 1'b1;
      bus_if.req_freq      = f;
      bus_if.req_phase_clr = c;
      step();
      bus_if.req_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.req_valid = 1'b0; bus_if.req_freq = '0; bus_if.req_phase_clr = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({bus_if.req_ready, bus_if.mix_en, bus_if.flush, bus_if.tuned} !== 4'b0000 ||
          bus_if.phase_idx !== '0 || bus_if.cur_freq !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: rdy/mix/flush/tuned=%b idx=%h cur=%h expected all 0",
                  {bus_if.req_ready, bus_if.mix_en, bus_if.flush, bus_if.tuned}, bus_if.phase_idx, bus_if.cur_freq);
      end
      // request presented across reset release must be ignored
      bus_if.req_valid = 1'b1; bus_if.req_freq = 32'h1234_5678;
      rst_n = 1'b1;
      step();
      bus_if.req_valid = 1'b0;
      n_checks++;
      if (bus_if.req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready_after_release: got %b expected 1", bus_if.req_ready);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if (bus_if.req_ready !== 1'b1 || bus_if.mix_en !== 1'b0 || bus_if.flush !== 1'b0 ||
             bus_if.phase_idx !== '0 || bus_if.cur_freq !== '0) begin
            n_errors++;
            $display("FAIL idle_static: rdy=%b mix=%b flush=%b idx=%h cur=%h expected 1/0/0/0/0",
                     bus_if.req_ready, bus_if.mix_en, bus_if.flush, bus_if.phase_idx, bus_if.cur_freq);
         end
      end
   endtask

   task automatic test_tune_from_idle();
      logic [LB-1:0] e_idx;
      do_request(32'h0100_0000, 1'b1);
      for (int k = 1; k <= M + S + 3; k++) begin
         n_checks++;
         if (bus_if.mix_en !== (k >= M + 2)) begin
            n_errors++;
            $display("FAIL tune_mix_en k=%0d: got %b expected %b", k, bus_if.mix_en, (k >= M + 2));
         end
         n_checks++;
         if (bus_if.flush !== (k == M + 1)) begin
            n_errors++;
            $display("FAIL tune_flush k=%0d: got %b expected %b", k, bus_if.flush, (k == M + 1));
         end
         n_checks++;
         if (bus_if.tuned !== (k >= M + S + 2) || bus_if.req_ready !== (k >= M + S + 2)) begin
            n_errors++;
            $display("FAIL tune_tuned_ready k=%0d: got %b/%b expected %b", k, bus_if.tuned, bus_if.req_ready, (k >= M + S + 2));
         end
         if (k >= M + 3) begin
            e_idx = LB'(4 * (k - M - 3));
            n_checks++;
            if (bus_if.phase_idx !== e_idx) begin
               n_errors++;
               $display("FAIL tune_phase_idx k=%0d: got %h expected %h", k, bus_if.phase_idx, e_idx);
            end
         end
         if (k < M + S + 3) step();
      end
   endtask

   task automatic test_wrap();
      do_request(32'hFFFF_FFFF, 1'b1);
      for (int k = 1; k <= M + S + 2; k++) begin
         if (k == 1) begin
            n_checks++;
            if (bus_if.tuned !== 1'b0 || bus_if.mix_en !== 1'b0) begin
               n_errors++;
               $display("FAIL wrap_tuned_fall: tuned=%b mix=%b expected 0/0", bus_if.tuned, bus_if.mix_en);
            end
         end
         if (k == M + 3) begin
            n_checks++;
            if (bus_if.phase_idx !== 10'h000) begin
               n_errors++;
               $display("FAIL wrap_idx_clr: got %h expected 000", bus_if.phase_idx);
            end
         end
         if (k >= M + 4 && k <= M + 6) begin
            n_checks++;
            if (bus_if.phase_idx !== 10'h3FF) begin
               n_errors++;
               $display("FAIL wrap_idx k=%0d: got %h expected 3ff", k, bus_if.phase_idx);
            end
         end
         if (k < M + S + 2) step();
      end
      n_checks++;
      if (bus_if.tuned !== 1'b1) begin
         n_errors++;
         $display("FAIL wrap_tuned: got %b expected 1", bus_if.tuned);
      end
   endtask

   task automatic test_retune_continuous();
      do_request(32'h0200_0000, 1'b0);
      for (int k = 1; k <= M + S + 2; k++) begin
         n_checks++;
         if (bus_if.tuned !== (k >= M + S + 2)) begin
            n_errors++;
            $display("FAIL retune_tuned k=%0d: got %b expected %b", k, bus_if.tuned, (k >= M + S + 2));
         end
         n_checks++;
         if (bus_if.cur_freq !== ((k >= M + 2) ? 32'h0200_0000 : 32'hFFFF_FFFF)) begin
            n_errors++;
            $display("FAIL retune_cur_freq k=%0d: got %h", k, bus_if.cur_freq);
         end
         if (k == M + 3 || k == M + 4 || k == M + 5) begin
            n_checks++;
            if (bus_if.phase_idx !== ((k == M + 3) ? 10'h3FF : (k == M + 4) ? 10'h007 : 10'h00F)) begin
               n_errors++;
               $display("FAIL retune_idx k=%0d: got %h (phase must not clear)", k, bus_if.phase_idx);
            end
         end
         if (k < M + S + 2) step();
      end
   endtask

   task automatic test_busy_reject();
      int n_flush;
      do_request(32'h0040_0000, 1'b1);
      // second request (freq 0) held valid through the whole busy window
      bus_if.req_valid = 1'b1; bus_if.req_freq = '0; bus_if.req_phase_clr = 1'b0;
      n_flush = 0;
      for (int k = 1; k <= M + S + 2; k++) begin
         n_checks++;
         if (bus_if.req_ready !== (k >= M + S + 2)) begin
            n_errors++;
            $display("FAIL busy_ready k=%0d: got %b expected %b", k, bus_if.req_ready, (k >= M + S + 2));
         end
         if (bus_if.flush === 1'b1) n_flush++;
         step();
      end
      bus_if.req_valid = 1'b0;
      n_checks++;
      if (n_flush != 1) begin
         n_errors++;
         $display("FAIL busy_flush_count: got %0d expected 1", n_flush);
      end
      n_flush = 0;
      for (int k = 1; k <= M + S + 2; k++) begin
         if (bus_if.flush === 1'b1) n_flush++;
         if (k == M + S + 2) begin
            n_checks++;
            if (bus_if.tuned !== 1'b1 || bus_if.cur_freq !== '0) begin
               n_errors++;
               $display("FAIL busy_second_tuned: tuned=%b cur=%h expected 1/0", bus_if.tuned, bus_if.cur_freq);
            end
         end else begin
            step();
         end
      end
      n_checks++;
      if (n_flush != 1) begin
         n_errors++;
         $display("FAIL busy_second_flush_count: got %0d expected 1", n_flush);
      end
   endtask

   task automatic test_same_freq();
      do_request(32'h0000_0000, 1'b0);
      for (int k = 1; k <= M + S + 2; k++) begin
         n_checks++;
         if (bus_if.flush !== (k == M + 1) || bus_if.tuned !== (k >= M + S + 2)) begin
            n_errors++;
            $display("FAIL same_freq k=%0d: flush=%b tuned=%b expected %b/%b", k, bus_if.flush, bus_if.tuned,
                     (k == M + 1), (k >= M + S + 2));
         end
         if (k < M + S + 2) step();
      end
   endtask

   task automatic test_reset_mid_settle();
      do_request(32'h0100_0000, 1'b0);
      for (int k = 1; k < M + 4; k++) step();
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus_if.req_ready, bus_if.mix_en, bus_if.flush, bus_if.tuned} !== 4'b0000 ||
          bus_if.phase_idx !== '0 || bus_if.cur_freq !== '0) begin
         n_errors++;
         $display("FAIL midreset_async: rdy/mix/flush/tuned=%b idx=%h cur=%h expected all 0",
                  {bus_if.req_ready, bus_if.mix_en, bus_if.flush, bus_if.tuned}, bus_if.phase_idx, bus_if.cur_freq);
      end
      step();
      #4;
      rst_n = 1'b1;
      step();
      n_checks++;
      if (bus_if.req_ready !== 1'b1 || bus_if.mix_en !== 1'b0 || bus_if.tuned !== 1'b0 || dbg_state !== 3'd0) begin
         n_errors++;
         $display("FAIL midreset_idle: rdy=%b mix=%b tuned=%b state=%0d expected 1/0/0/0",
                  bus_if.req_ready, bus_if.mix_en, bus_if.tuned, dbg_state);
      end
      do_request(32'h0040_0000, 1'b1);
      for (int k = 1; k <= M + S + 2; k++) begin
         n_checks++;
         if (bus_if.flush !== (k == M + 1) || bus_if.tuned !== (k >= M + S + 2)) begin
            n_errors++;
            $display("FAIL post_reset_seq k=%0d: flush=%b tuned=%b", k, bus_if.flush, bus_if.tuned);
         end
         if (k < M + S + 2) step();
      end
   endtask

   initial begin
      test_reset();
      test_tune_from_idle();
      test_wrap();
      test_retune_continuous();
      test_busy_reject();
      test_same_freq();
      test_reset_mid_settle();
      repeat (3) step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: %0d accepted requests without flush, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
